// File: rtl/stage_4_pkg.sv
// Shared constants for the memory-access stage: opcodes, LOAD/STORE func_3 codes,
// FSM state encoding and the register-writing opcode test.
package stage_4_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   function automatic logic writes_rd(input logic [6:0] opcode);
      return (opcode == OPC_OP)  || (opcode == OPC_OPIMM) || (opcode == OPC_JAL) ||
             (opcode == OPC_JALR) || (opcode == OPC_LUI)  || (opcode == OPC_AUIPC);
   endfunction

endpackage

// File: rtl/stage_4_mem_align.sv
// Combinational byte-lane steering: store byte enables / replicated write data,
// load extraction with sign/zero extension, and alignment/func_3 fault detection.
module stage_4_mem_align
   import stage_4_pkg::*;
(
   input  logic [2:0]  func_3,
   input  logic        is_store,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   output logic [31:0] load_data,
   output logic        fault
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        misaligned;
   logic        illegal;

   always_comb begin
      mem_be     = 4'b0000;
      mem_wdata  = store_data;
      misaligned = 1'b0;
      case (func_3[1:0])
         2'b00: begin
            mem_be    = 4'b0001 << addr_lo;
            mem_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            mem_be     = 4'b0011 << addr_lo;
            mem_wdata  = {2{store_data[15:0]}};
            misaligned = addr_lo[0];
         end
         2'b10: begin
            mem_be     = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         default: begin
            mem_be = 4'b0000;
         end
      endcase
   end

   // Loads accept 000,001,010,100,101; stores only the three signed widths.
   assign illegal = (func_3[1:0] == 2'b11) || (func_3 == 3'b110) || (is_store && func_3[2]);
   assign fault   = illegal || misaligned;

   assign byte_sel = rdata[8*addr_lo +: 8];
   assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      load_data = rdata;
      case (func_3)
         F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  load_data = {24'h000000, byte_sel};
         F3_LHU:  load_data = {16'h0000, half_sel};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/stage_4.sv
// Memory-access pipeline stage: IDLE/ACCESS FSM that issues data-memory requests for
// LOAD/STORE, passes other results through, and registers the writeback bundle.
module stage_4
   import stage_4_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [31:0] i_alu_out,
   input  logic [31:0] i_rs_2,
   input  logic [4:0]  i_rd_num,
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_func_3,
   input  logic        i_op_type,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        o_valid,
   output logic [4:0]  rd_num,
   output logic [31:0] wb_data,
   output logic        wb_en,
   output logic        mem_fault
);

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        o_valid_q, o_valid_d;
   logic [4:0]  rd_num_q, rd_num_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_en_q, wb_en_d;
   logic        mem_fault_q, mem_fault_d;
   logic [2:0]  func3_q, func3_d;
   logic [1:0]  lane_q, lane_d;
   logic [4:0]  pend_rd_q, pend_rd_d;

   logic        in_store;
   logic [2:0]  al_func3;
   logic        al_store;
   logic [1:0]  al_lane;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_load;
   logic        al_fault;

   assign in_store = (i_opcode == OPC_STORE);

   // The aligner sees the incoming bundle while idle and the latched op during ACCESS.
   always_comb begin
      al_func3 = i_func_3;
      al_store = in_store;
      al_lane  = i_alu_out[1:0];
      if (state_q == ST_ACCESS) begin
         al_func3 = func3_q;
         al_store = mem_we_q;
         al_lane  = lane_q;
      end
   end

   stage_4_mem_align u_align (
      .func_3     (al_func3),
      .is_store   (al_store),
      .addr_lo    (al_lane),
      .store_data (i_rs_2),
      .rdata      (mem_rdata),
      .mem_be     (al_be),
      .mem_wdata  (al_wdata),
      .load_data  (al_load),
      .fault      (al_fault)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rd_num_d    = rd_num_q;
      wb_data_d   = wb_data_q;
      func3_d     = func3_q;
      lane_d      = lane_q;
      pend_rd_d   = pend_rd_q;
      o_valid_d   = 1'b0;
      wb_en_d     = 1'b0;
      mem_fault_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               rd_num_d = i_rd_num;
               if (!i_op_type) begin
                  o_valid_d = 1'b1;
                  wb_data_d = i_alu_out;
                  wb_en_d   = writes_rd(i_opcode) && (i_rd_num != 5'd0);
               end else if (al_fault) begin
                  o_valid_d   = 1'b1;
                  mem_fault_d = 1'b1;
                  wb_data_d   = 32'h0;
               end else begin
                  state_d     = ST_ACCESS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = in_store;
                  mem_addr_d  = {i_alu_out[31:2], 2'b00};
                  mem_be_d    = in_store ? al_be : 4'b0000;
                  mem_wdata_d = in_store ? al_wdata : 32'h0;
                  func3_d     = i_func_3;
                  lane_d      = i_alu_out[1:0];
                  pend_rd_d   = i_rd_num;
               end
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               o_valid_d = 1'b1;
               rd_num_d  = pend_rd_q;
               wb_data_d = mem_we_q ? 32'h0 : al_load;
               wb_en_d   = !mem_we_q && (pend_rd_q != 5'd0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'h0;
         o_valid_q   <= 1'b0;
         rd_num_q    <= 5'd0;
         wb_data_q   <= 32'h0;
         wb_en_q     <= 1'b0;
         mem_fault_q <= 1'b0;
         func3_q     <= 3'b000;
         lane_q      <= 2'b00;
         pend_rd_q   <= 5'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         o_valid_q   <= o_valid_d;
         rd_num_q    <= rd_num_d;
         wb_data_q   <= wb_data_d;
         wb_en_q     <= wb_en_d;
         mem_fault_q <= mem_fault_d;
         func3_q     <= func3_d;
         lane_q      <= lane_d;
         pend_rd_q   <= pend_rd_d;
      end
   end

   assign stall     = (state_q == ST_ACCESS);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign o_valid   = o_valid_q;
   assign rd_num    = rd_num_q;
   assign wb_data   = wb_data_q;
   assign wb_en     = wb_en_q;
   assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_stage_4.sv
// Randomized scoreboard bench for stage_4: the driver queues expected writeback bundles
// from an arithmetic reference model, a negedge monitor pops and compares on o_valid.
module tb_stage_4;

   localparam logic [6:0] T_OP     = 7'b0110011;
   localparam logic [6:0] T_OPIMM  = 7'b0010011;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_JALR   = 7'b1100111;
   localparam logic [6:0] T_LUI    = 7'b0110111;
   localparam logic [6:0] T_AUIPC  = 7'b0010111;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_SYSTEM = 7'b1110011;

   logic        clk;
   logic        reset;
   logic        i_valid;
   logic [31:0] i_alu_out;
   logic [31:0] i_rs_2;
   logic [4:0]  i_rd_num;
   logic [6:0]  i_opcode;
   logic [2:0]  i_func_3;
   logic        i_op_type;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        o_valid;
   logic [4:0]  rd_num;
   logic [31:0] wb_data;
   logic        wb_en;
   logic        mem_fault;

   typedef struct packed {
      logic [31:0] wb;
      logic        en;
      logic [4:0]  rd;
      logic        fault;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   stage_4 dut (
      .clk       (clk),
      .reset     (reset),
      .i_valid   (i_valid),
      .i_alu_out (i_alu_out),
      .i_rs_2    (i_rs_2),
      .i_rd_num  (i_rd_num),
      .i_opcode  (i_opcode),
      .i_func_3  (i_func_3),
      .i_op_type (i_op_type),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .o_valid   (o_valid),
      .rd_num    (rd_num),
      .wb_data   (wb_data),
      .wb_en     (wb_en),
      .mem_fault (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int access_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic is_fault(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr);
      int  sz;
      logic legal;
      sz = access_size(f3);
      if (opc == T_STORE) legal = (f3 <= 3'd2);
      else                legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal || sz == 0) return 1'b1;
      return (int'(addr[1:0]) % sz) != 0;
   endfunction

   function automatic exp_t model(input logic [6:0] opc, input logic op_type, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] rdata);
      exp_t e;
      int   sz;
      logic [31:0] mask;
      logic [31:0] v;
      e.rd = rd; e.fault = 1'b0; e.en = 1'b0; e.wb = 32'h0;
      if (!op_type) begin
         e.wb = addr;
         e.en = (rd != 0) && (opc inside {T_OP, T_OPIMM, T_JAL, T_JALR, T_LUI, T_AUIPC});
         return e;
      end
      if (is_fault(opc, f3, addr)) begin
         e.fault = 1'b1;
         return e;
      end
      if (opc == T_STORE) return e;
      sz   = access_size(f3);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = (rdata >> (8 * int'(addr[1:0]))) & mask;
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      e.wb = v;
      e.en = (rd != 0);
      return e;
   endfunction

   // Monitor: every o_valid must match the oldest expectation; wb_en/mem_fault never outside it.
   always @(negedge clk) begin
      if (!reset) begin
         if (o_valid) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_o_valid: got=1 want=0 at %0t", $time);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("wb_data", wb_data, e.wb);
               chk("wb_en", 32'(wb_en), 32'(e.en));
               chk("rd_num", 32'(rd_num), 32'(e.rd));
               chk("mem_fault", 32'(mem_fault), 32'(e.fault));
               $display("txn rd=%0d wb_data=0x%08h wb_en=%0b fault=%0b", rd_num, wb_data, wb_en, mem_fault);
            end
         end else begin
            chk("pulse_idle", {30'd0, wb_en, mem_fault}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                        input int waits);
      logic memop;
      logic st;
      int   sz;
      exp_t e;
      memop = (opc == T_LOAD) || (opc == T_STORE);
      st    = (opc == T_STORE);
      e     = model(opc, memop, f3, addr, rd, rdata);
      sb.push_back(e);
      i_valid = 1'b1; i_opcode = opc; i_op_type = memop; i_func_3 = f3;
      i_alu_out = addr; i_rs_2 = rs2; i_rd_num = rd;
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      i_valid = 1'b0; mem_ack = 1'b0;
      i_alu_out = $urandom; i_rs_2 = $urandom; i_rd_num = 5'($urandom); i_func_3 = 3'($urandom);
      if (!memop || e.fault) begin
         chk("lat1_o_valid", 32'(o_valid), 32'd1);
         chk("lat1_stall", 32'(stall), 32'd0);
         chk("lat1_mem_req", 32'(mem_req), 32'd0);
      end else begin
         sz = access_size(f3);
         chk("req_rise", 32'(mem_req), 32'd1);
         chk("stall_access", 32'(stall), 32'd1);
         chk("mem_we", 32'(mem_we), 32'(st));
         chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
         if (st) begin
            chk("mem_be", 32'(mem_be), ((32'd1 << sz) - 32'd1) << addr[1:0]);
            chk("mem_wdata", mem_wdata, (sz == 1) ? rs2[7:0] * 32'h0101_0101 :
                                        (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2);
         end else begin
            chk("mem_be_load", 32'(mem_be), 32'd0);
         end
         for (int w = 0; w < waits; w++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_op_type = 1'b0; i_opcode = T_OP;
            @(posedge clk); #1;
            chk("req_held", 32'(mem_req), 32'd1);
            chk("stall_held", 32'(stall), 32'd1);
            chk("no_early_valid", 32'(o_valid), 32'd0);
            chk("addr_held", mem_addr, addr & 32'hFFFF_FFFC);
         end
         i_valid = 1'b0;
         mem_ack = 1'b1; mem_rdata = rdata;
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = $urandom;
         chk("ack_o_valid", 32'(o_valid), 32'd1);
         chk("ack_req_drop", 32'(mem_req), 32'd0);
         chk("ack_stall_low", 32'(stall), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0]  opc_tab [10];
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          sz;
      opc_tab = '{T_OP, T_OPIMM, T_JAL, T_JALR, T_LUI, T_AUIPC, T_LOAD, T_STORE, T_BRANCH, T_SYSTEM};

      reset = 1'b1; i_valid = 1'b0; i_alu_out = '0; i_rs_2 = '0; i_rd_num = '0;
      i_opcode = '0; i_func_3 = '0; i_op_type = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {26'd0, stall, mem_req, mem_we, o_valid, wb_en, mem_fault}, 32'd0);
      chk("rst_bus", mem_addr | mem_wdata | wb_data | 32'(mem_be) | 32'(rd_num), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases from the stage's intended behaviour.
      issue(T_OPIMM, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0);
      issue(T_LOAD, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 32'h80FF_0000, 0);
      issue(T_LOAD, 3'b100, 32'h0000_0103, 32'h0, 5'd8, 32'h80FF_0000, 0);
      issue(T_STORE, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd9, 32'h0, 3);
      issue(T_LOAD, 3'b010, 32'h0000_0101, 32'h0, 5'd10, 32'h0, 0);
      issue(T_LOAD, 3'b010, 32'h0000_0400, 32'h0, 5'd0, 32'hCAFE_F00D, 1);
      issue(T_LOAD, 3'b101, 32'h0000_0502, 32'h0, 5'd11, 32'h9ABC_1234, 2);
      issue(T_STORE, 3'b100, 32'h0000_0600, 32'h0, 5'd12, 32'h0, 0);
      issue(T_LOAD, 3'b110, 32'h0000_0700, 32'h0, 5'd13, 32'h0, 0);
      issue(T_STORE, 3'b000, 32'h0000_0803, 32'h0000_00A5, 5'd14, 32'h0, 0);

      // Reset while a store waits; a stray ack afterwards must be ignored.
      i_valid = 1'b1; i_opcode = T_STORE; i_op_type = 1'b1; i_func_3 = 3'b010;
      i_alu_out = 32'h0000_0900; i_rs_2 = 32'h1122_3344; i_rd_num = 5'd3;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("abandon_req", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abandon_ctrl", {26'd0, stall, mem_req, mem_we, o_valid, wb_en, mem_fault}, 32'd0);
      chk("abandon_bus", mem_addr | mem_wdata | wb_data | 32'(mem_be) | 32'(rd_num), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("stray_ack", {29'd0, stall, mem_req, o_valid}, 32'd0);
      issue(T_OPIMM, 3'b000, 32'h0000_00AB, 32'h0, 5'd1, 32'h0, 0);

      for (int n = 0; n < 300; n++) begin
         opc  = opc_tab[$urandom_range(0, 9)];
         f3   = 3'($urandom);
         addr = $urandom;
         if ((opc == T_LOAD || opc == T_STORE) && $urandom_range(0, 1) == 1) begin
            if (opc == T_STORE) f3 = 3'($urandom_range(0, 2));
            else                f3 = (n % 2 == 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
            sz = access_size(f3);
            addr[1:0] = 2'(($urandom_range(0, 3) / sz) * sz);
         end
         issue(opc, f3, addr, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
               $urandom, $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stage_4.md
# stage_4

Memory-access stage of the five-stage RISC-V pipeline, consuming the execute stage's result bundle (ALU result, rs_2, destination register, opcode, func_3, memory-op flag). It turns LOAD/STORE operations into a request/acknowledge transaction on the data-memory port, with byte-lane steering and load sign/zero extension. All other operations pass through to writeback. It stalls upstream while a memory transaction is outstanding.

## Interface
Parameters:
- none.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- i_valid  in  1  execute-stage bundle valid this cycle
- i_alu_out  in  32  ALU result / effective address
- i_rs_2  in  32  store data
- i_rd_num  in  5  destination register
- i_opcode  in  7  instruction opcode
- i_func_3  in  3  width/sign selector
- i_op_type  in  1  1 = LOAD/STORE
- stall  out  1  high while not IDLE; upstream holds, i_valid ignored
- mem_req  out  1  request, held until mem_ack
- mem_we  out  1  1 = store
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  transaction complete; mem_rdata valid same cycle
- mem_rdata  in  32  read word
- o_valid  out  1  one-cycle pulse, result bundle valid
- rd_num  out  5  destination register
- wb_data  out  32  writeback value
- wb_en  out  1  register write enable
- mem_fault  out  1  misaligned or illegal func_3, qualified by o_valid

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, i_valid, i_op_type=0:
  - Next edge: o_valid=1, wb_data=i_alu_out, rd_num=i_rd_num.
  - wb_en=1 for OP, OPIMM, JAL, JALR, LUI, AUIPC with rd≠0; else 0.
- IDLE, i_valid, i_op_type=1, fault:
  - Fault = half with addr[0]=1, word with addr[1:0]≠0, or func_3 ∈ {011,110,111} (stores: also 1xx).
  - Next edge: o_valid=1, mem_fault=1, wb_en=0. No request issued; stays IDLE.
- IDLE, aligned memory op:
  - Latch address, data, rd, func_3 and direction.
  - Next edge: state ACCESS, mem_req=1.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata held stable.
  - On the mem_ack cycle, next edge: mem_req=0, o_valid=1, state IDLE.
  - Load: wb_data=extracted value, wb_en=(rd≠0).
  - Store: wb_en=0, wb_data=0.
- Byte enables (addr lane L = addr[1:0]):
  - SB: 4'b0001<<L. SH: 4'b0011<<L (L ∈ {0,2}). SW: 4'b1111.
- Write data: SB {4{rs_2[7:0]}}, SH {2{rs_2[15:0]}}, SW rs_2.
- Load extraction: select byte L or half L[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- mem_ack in IDLE is ignored.
- rd=0 is never written (wb_en=0), even for loads.

## Timing
- Reset: state IDLE; stall, mem_req, mem_we, o_valid, wb_en, mem_fault = 0; mem_addr, mem_be, mem_wdata, wb_data, rd_num = 0.
- Non-memory op or fault: latency 1 cycle, stall never asserted.
- Memory op: mem_req rises 1 cycle after capture.
- Zero-wait ack (mem_ack in the first ACCESS cycle): o_valid 2 cycles after capture. Each wait cycle adds 1.
- stall is combinational from state (high throughout ACCESS). stall is low in the o_valid cycle, so a new bundle may be accepted then.
- o_valid, wb_en and mem_fault are single-cycle pulses.
- Reset during ACCESS: mem_req drops at the reset edge and the transaction is abandoned. A later mem_ack is ignored. No o_valid is produced.

## Structure
- constants.vh gains:
  - LOAD/STORE func_3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state encodings (IDLE, ACCESS).
  - Reuse existing opcode macros (OP, OPIMM, JAL, JALR, LUI, AUIPC, LOAD, STORE).
- One combinational sub-module, mem_align:
  - Inputs: func_3, addr[1:0], store data, read word.
  - Outputs: mem_be, mem_wdata, extended load value, fault.
  - stage_4 holds the FSM and output registers only.

## Test plan
- ADDI bundle, alu_out=0x1234, rd=5 → next cycle o_valid=1, wb_data=0x1234, wb_en=1, stall never high.
- LB addr 0x103, mem_rdata=0x80FF_0000, zero-wait ack → mem_addr=0x100, mem_be=0000 not used for loads (read ignores be); wb_data=0xFFFF_FF80, o_valid 2 cycles after capture. LBU same → 0x0000_0080.
- SH addr 0x202, rs_2=0xDEAD_BEEF, ack after 3 wait cycles → mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, mem_req held 4 cycles, wb_en=0, stall high exactly 4 cycles.
- LW addr 0x101 → next cycle o_valid=1, mem_fault=1, wb_en=0, mem_req never asserted.
- LW to rd=0 with mem_rdata=0xCAFE_F00D → o_valid=1, wb_en=0.
- SW issued, reset asserted during wait, stray mem_ack afterwards → all outputs 0 after reset edge, no o_valid, next ADDI handled normally.
